// File: rtl/vga_text_pixel_gen.sv
// +------------------------------------------------------------------------+
// | vga_text_pixel_gen: 80x30 text-mode pixel pipeline for 640x480 VGA      |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module vga_text_pixel_gen #(
  parameter int BLINK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        visible,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  output logic [11:0] charAddr,
  input  logic [15:0] charData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
  output logic        pixel,
  output logic        fgRed,
  output logic        fgGreen,
  output logic        fgBlue,
  output logic        fgIntense,
  output logic        bgRed,
  output logic        bgGreen,
  output logic        bgBlue,
  output logic        bgIntense,
  output logic        hSyncOut,
  output logic        vSyncOut
);

  logic [4:0]  w_cellRow;
  logic [11:0] w_charAddr;
  logic        w_blink;
  logic        w_fontBit;
  logic        w_vsFall;
  logic        w_unused_vcount_msb;

  // Stage A
  logic [2:0] r_colA;
  logic [3:0] r_rowA;
  logic       r_visA, r_hsA, r_vsA, r_vsPrev;
  // Stage B
  logic [2:0] r_colB;
  logic [3:0] r_rowB;
  logic       r_visB, r_hsB, r_vsB;
  // Stage C
  logic [2:0] r_colC;
  logic [7:0] r_attrC;
  logic       r_visC, r_hsC, r_vsC;
  // Stage D
  logic [2:0] r_colD;
  logic [7:0] r_attrD;
  logic       r_visD, r_hsD, r_vsD;

  logic [BLINK_LOG2:0] r_frameCnt;

  assign w_cellRow           = vCount[8:4];
  // row*80 as (row<<6)+(row<<4), avoiding a multiplier
  assign w_charAddr          = ({7'd0, w_cellRow} << 6) + ({7'd0, w_cellRow} << 4)
                             + {5'd0, hCount[9:3]};
  assign w_blink             = r_frameCnt[BLINK_LOG2];
  assign w_fontBit           = fontData[3'd7 - r_colD];
  assign w_vsFall            = r_vsPrev & ~r_vsA;
  assign w_unused_vcount_msb = vCount[9];

  always_ff @(posedge clk) begin
    if (reset) begin
      charAddr   <= '0;
      r_colA     <= '0;
      r_rowA     <= '0;
      r_visA     <= 1'b0;
      r_hsA      <= 1'b1;
      r_vsA      <= 1'b1;
      r_vsPrev   <= 1'b1;
      r_colB     <= '0;
      r_rowB     <= '0;
      r_visB     <= 1'b0;
      r_hsB      <= 1'b1;
      r_vsB      <= 1'b1;
      fontAddr   <= '0;
      r_colC     <= '0;
      r_attrC    <= '0;
      r_visC     <= 1'b0;
      r_hsC      <= 1'b1;
      r_vsC      <= 1'b1;
      r_colD     <= '0;
      r_attrD    <= '0;
      r_visD     <= 1'b0;
      r_hsD      <= 1'b1;
      r_vsD      <= 1'b1;
      r_frameCnt <= '0;
      pixel      <= 1'b0;
      fgRed      <= 1'b0;
      fgGreen    <= 1'b0;
      fgBlue     <= 1'b0;
      fgIntense  <= 1'b0;
      bgRed      <= 1'b0;
      bgGreen    <= 1'b0;
      bgBlue     <= 1'b0;
      bgIntense  <= 1'b0;
      hSyncOut   <= 1'b1;
      vSyncOut   <= 1'b1;
    end else begin
      charAddr <= w_charAddr;
      r_colA   <= hCount[2:0];
      r_rowA   <= vCount[3:0];
      r_visA   <= visible;
      r_hsA    <= hSyncIn;
      r_vsA    <= vSyncIn;
      r_vsPrev <= r_vsA;

      r_colB <= r_colA;
      r_rowB <= r_rowA;
      r_visB <= r_visA;
      r_hsB  <= r_hsA;
      r_vsB  <= r_vsA;

      // Text RAM data for the stage-A address lands here
      fontAddr <= {charData[7:0], r_rowB};
      r_attrC  <= charData[15:8];
      r_colC   <= r_colB;
      r_visC   <= r_visB;
      r_hsC    <= r_hsB;
      r_vsC    <= r_vsB;

      r_attrD <= r_attrC;
      r_colD  <= r_colC;
      r_visD  <= r_visC;
      r_hsD   <= r_hsC;
      r_vsD   <= r_vsC;

      if (w_vsFall) begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end

      if (r_visD) begin
        pixel     <= w_fontBit & ~(r_attrD[7] & w_blink);
        fgIntense <= r_attrD[3];
        fgRed     <= r_attrD[2];
        fgGreen   <= r_attrD[1];
        fgBlue    <= r_attrD[0];
        bgRed     <= r_attrD[6];
        bgGreen   <= r_attrD[5];
        bgBlue    <= r_attrD[4];
      end else begin
        pixel     <= 1'b0;
        fgIntense <= 1'b0;
        fgRed     <= 1'b0;
        fgGreen   <= 1'b0;
        fgBlue    <= 1'b0;
        bgRed     <= 1'b0;
        bgGreen   <= 1'b0;
        bgBlue    <= 1'b0;
      end
      bgIntense <= 1'b0;
      hSyncOut  <= r_hsD;
      vSyncOut  <= r_vsD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_text_pixel_gen.sv
// +------------------------------------------------------------------------+
// | tb_vga_text_pixel_gen: scoreboard bench for vga_text_pixel_gen          |
// | Rev 1.0 - initial release                                               |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_vga_text_pixel_gen;

  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        visible = 1'b0;
  logic        hSyncIn = 1'b1;
  logic        vSyncIn = 1'b1;
  logic [11:0] charAddr;
  logic [15:0] charData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic        pixel;
  logic        fgRed, fgGreen, fgBlue, fgIntense;
  logic        bgRed, bgGreen, bgBlue, bgIntense;
  logic        hSyncOut, vSyncOut;

  vga_text_pixel_gen #(.BLINK_LOG2(BL)) dut (
    .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
    .visible(visible), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .charAddr(charAddr), .charData(charData), .fontAddr(fontAddr),
    .fontData(fontData), .pixel(pixel),
    .fgRed(fgRed), .fgGreen(fgGreen), .fgBlue(fgBlue), .fgIntense(fgIntense),
    .bgRed(bgRed), .bgGreen(bgGreen), .bgBlue(bgBlue), .bgIntense(bgIntense),
    .hSyncOut(hSyncOut), .vSyncOut(vSyncOut)
  );

  always #5 clk = ~clk;

  logic [15:0] tram [0:4095];
  logic [7:0]  font [0:4095];

  // Synchronous 1-cycle-read memories
  always @(posedge clk) begin
    charData <= tram[charAddr];
    fontData <= font[fontAddr];
  end

  logic [10:0] w_obs;
  assign w_obs = {pixel, fgIntense, fgRed, fgGreen, fgBlue,
                  bgIntense, bgRed, bgGreen, bgBlue, hSyncOut, vSyncOut};

  int          nChecks = 0;
  int          nFails = 0;
  int          cyc = 0;
  int          lastRst = -100;
  logic [10:0] sbq [$];
  logic [11:0] expCA [0:2047];
  logic [11:0] expFA [0:2047];
  logic [BL:0] frames = '0;
  logic        prevVs = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic [9:0] h, input logic [9:0] v,
                                        input logic vis, input logic hs, input logic vs,
                                        input logic blink);
    int          addr;
    logic [15:0] cd;
    logic [7:0]  fb;
    logic        pix;
    if (!vis) return {9'd0, hs, vs};
    addr = int'(v[8:4]) * 80 + int'(h[9:3]);
    cd   = tram[addr];
    fb   = font[{cd[7:0], v[3:0]}];
    pix  = fb[7 - int'(h[2:0])] & ~(cd[15] & blink);
    return {pix, cd[11], cd[10], cd[9], cd[8], 1'b0, cd[14], cd[13], cd[12], hs, vs};
  endfunction

  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic vis,
                      input logic hs, input logic vs, input logic rst);
    logic [10:0] e;
    int          addr;
    @(negedge clk);
    if (sbq.size() == 5) begin
      e = sbq.pop_front();
      check("outputs", {21'd0, w_obs}, {21'd0, e});
    end
    if (cyc >= 1) check("charAddr", {20'd0, charAddr}, {20'd0, expCA[cyc-1]});
    if (cyc >= 3 && lastRst < cyc - 3) check("fontAddr", {20'd0, fontAddr}, {20'd0, expFA[cyc-3]});
    hCount  = h;
    vCount  = v;
    visible = vis;
    hSyncIn = hs;
    vSyncIn = vs;
    reset   = rst;
    addr = int'(v[8:4]) * 80 + int'(h[9:3]);
    if (rst) begin
      foreach (sbq[i]) sbq[i] = {9'd0, 2'b11};
      sbq.push_back({9'd0, 2'b11});
      frames     = '0;
      prevVs     = 1'b1;
      lastRst    = cyc;
      expCA[cyc] = '0;
      expFA[cyc] = '0;
    end else begin
      if (prevVs && !vs) frames = frames + 1'b1;
      prevVs = vs;
      sbq.push_back(model(h, v, vis, hs, vs, frames[BL]));
      expCA[cyc] = addr[11:0];
      expFA[cyc] = {tram[addr][7:0], v[3:0]};
    end
    cyc++;
  endtask

  task automatic sweep_cell(input int x0, input int y);
    for (int i = 0; i < 8; i++) step(10'(x0 + i), 10'(y), 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Two-cycle vSync low pulses in blanking, then enough idle to settle the counter
  task automatic vs_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      step(10'd650, 10'd490, 1'b0, 1'b1, 1'b0, 1'b0);
      step(10'd651, 10'd490, 1'b0, 1'b1, 1'b0, 1'b0);
      step(10'd652, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0);
      step(10'd653, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) step(10'd660, 10'd490, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'($urandom);
      font[i] = 8'($urandom);
    end
    tram[0]      = 16'h1F41;
    font[12'h410] = 8'h81;
    tram[1]      = 16'h8742;
    font[12'h420] = 8'hAA;
    tram[2]      = 16'h0F43;
    font[12'h430] = 8'hFF;

    for (int i = 0; i < 3; i++) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(10'd790, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0);

    sweep_cell(0, 0);

    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 1'b0);
    step(10'd0,   10'd479, 1'b0, 1'b1, 1'b1, 1'b0);

    // Blanked cell whose font row is all ones
    for (int i = 0; i < 8; i++) step(10'(16 + i), 10'd0, 1'b0, (i != 3), 1'b1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      logic [9:0] h, v;
      h = 10'($urandom_range(0, 799));
      v = 10'($urandom_range(0, 524));
      step(h, v, (h < 640 && v < 480), ($urandom_range(0, 7) != 0), 1'b1, 1'b0);
    end

    // Single-cycle hSync pulse among visible pixels
    for (int i = 0; i < 8; i++) step(10'(100 + i), 10'd37, 1'b1, (i != 4), 1'b1, 1'b0);

    // Reset mid-line, then resume the line
    for (int i = 0; i < 10; i++) step(10'(200 + i), 10'd50, 1'b1, 1'b1, 1'b1, (i >= 3 && i < 6));

    sweep_cell(8, 0);
    vs_pulses(2);
    sweep_cell(8, 0);
    sweep_cell(0, 0);
    vs_pulses(2);
    sweep_cell(8, 0);

    for (int i = 0; i < 6; i++) step(10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
